// File: rtl/mips_datapath_if.sv
// -----------------------------------------------------------------------------
// mips_datapath_if
//   Bundles the control-unit lines, the instruction word from fetch, and the
//   values returned to fetch for branch and jump-register targets.
//
//   master : control unit + fetch unit side (drives control lines and the
//            instruction word, consumes Zero/seOut/reg_Da)
//   slave  : datapath side
//
//   RegDst        1   write-reg select: 1 = Rd, 0 = Rt
//   RegWr         1   register file write enable
//   ALUsrc        1   ALU B operand: 1 = seOut, 0 = Db
//   ALUcntrl      2   00 add, 01 sub, 10 and, 11 or
//   MemWr         1   data memory write enable
//   MemToReg      1   write-back select: 1 = memory, 0 = ALU
//   Instructions  32  current instruction word
//   Zero          1   ALU result == 0
//   seOut         32  sign-extended Instructions[15:0]
//   reg_Da        32  register file read data for Rs
// -----------------------------------------------------------------------------
interface mips_datapath_if;
    logic        RegDst;
    logic        RegWr;
    logic        ALUsrc;
    logic [1:0]  ALUcntrl;
    logic        MemWr;
    logic        MemToReg;
    logic [31:0] Instructions;
    logic        Zero;
    logic [31:0] seOut;
    logic [31:0] reg_Da;

    modport master (
        output RegDst, RegWr, ALUsrc, ALUcntrl, MemWr, MemToReg, Instructions,
        input  Zero, seOut, reg_Da
    );

    modport slave (
        input  RegDst, RegWr, ALUsrc, ALUcntrl, MemWr, MemToReg, Instructions,
        output Zero, seOut, reg_Da
    );
endinterface

// File: rtl/mips_datapath.sv
// -----------------------------------------------------------------------------
// mips_datapath
//   Single-cycle 32-bit MIPS execution datapath: 32x32 register file, sign
//   extender, 4-function ALU, word-addressed data memory and write-back mux.
//   Everything visible on the bus is combinational from the current inputs and
//   the stored state; registers and memory update on the rising clock edge.
//
//   Ports
//     clk    in  clock, all state updates on rising edge
//     rst_n  in  asynchronous active-low reset; clears registers and memory
//     bus    slave side of mips_datapath_if (control lines, instruction word,
//            Zero / seOut / reg_Da back to fetch)
//
//   Parameters
//     DMEM_WORDS  data memory depth in 32-bit words (power of 2, >= 2)
// -----------------------------------------------------------------------------
module mips_datapath #(
    parameter int DMEM_WORDS = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    mips_datapath_if.slave  bus
);

    localparam int AW = $clog2(DMEM_WORDS);

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;

    assign rs  = bus.Instructions[25:21];
    assign rt  = bus.Instructions[20:16];
    assign rd  = bus.Instructions[15:11];
    assign imm = bus.Instructions[15:0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] regs [32];
    logic [31:0] dmem [DMEM_WORDS];

    // ------------------------------------------------------------------
    // Register file read ports. Register 0 is never written, but the read
    // is masked too so $0 reads zero regardless of what the array holds.
    // ------------------------------------------------------------------
    logic [31:0] da, db;

    assign da = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign db = (rt == 5'd0) ? 32'd0 : regs[rt];

    // ------------------------------------------------------------------
    // Sign extension
    // ------------------------------------------------------------------
    logic [31:0] se;

    assign se = {{16{imm[15]}}, imm};

    // ------------------------------------------------------------------
    // ALU: wrap-around add/sub, bitwise and/or, no overflow detection
    // ------------------------------------------------------------------
    logic [31:0] alu_a, alu_b, alu_res;

    assign alu_a = da;
    assign alu_b = bus.ALUsrc ? se : db;

    always_comb begin
        alu_res = 32'd0;
        case (bus.ALUcntrl)
            ALU_ADD: alu_res = alu_a + alu_b;
            ALU_SUB: alu_res = alu_a - alu_b;
            ALU_AND: alu_res = alu_a & alu_b;
            ALU_OR:  alu_res = alu_a | alu_b;
            default: alu_res = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Data memory addressing: the ALU result is a byte address; only the
    // word-index bits are decoded, so higher bits alias and the byte offset
    // is dropped.
    // ------------------------------------------------------------------
    logic [AW-1:0] widx;
    logic [31:0]   mem_rd;

    assign widx   = alu_res[AW+1:2];
    assign mem_rd = dmem[widx];

    // ------------------------------------------------------------------
    // Write-back
    // ------------------------------------------------------------------
    logic [4:0]  wa;
    logic [31:0] wb;
    logic        reg_we;

    assign wa     = bus.RegDst ? rd : rt;
    assign wb     = bus.MemToReg ? mem_rd : alu_res;
    // Gate with wa only when the write is actually enabled so an undriven
    // RegDst/MemToReg on store cycles can never reach the array.
    assign reg_we = bus.RegWr && (wa != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (reg_we) begin
            regs[wa] <= wb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= 32'd0;
        end else if (bus.MemWr) begin
            dmem[widx] <= db;
        end
    end

    // ------------------------------------------------------------------
    // Outputs back to fetch
    // ------------------------------------------------------------------
    assign bus.Zero   = ~|alu_res;
    assign bus.seOut  = se;
    assign bus.reg_Da = da;

    // Opcode / funct bits and the aliased address bits are intentionally
    // not decoded here.
    logic unused_bits;
    assign unused_bits = ^{bus.Instructions[31:26], alu_res[31:AW+2], alu_res[1:0]};

endmodule

// File: tb/tb_mips_datapath.sv
module tb_mips_datapath;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    mips_datapath_if bus ();

    mips_datapath #(.DMEM_WORDS(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] itype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {6'h08, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input logic regdst, input logic regwr, input logic alusrc,
                       input logic [1:0] aluc, input logic memwr, input logic memtoreg,
                       input logic [31:0] instr);
        bus.RegDst       = regdst;
        bus.RegWr        = regwr;
        bus.ALUsrc       = alusrc;
        bus.ALUcntrl     = aluc;
        bus.MemWr        = memwr;
        bus.MemToReg     = memtoreg;
        bus.Instructions = instr;
    endtask

    // one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // read a register through the Rs port with all writes disabled
    task automatic rdreg(input logic [4:0] r, input logic [31:0] exp, input string tag);
        ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, {6'h00, r, 21'd0});
        #1;
        chk(tag, bus.reg_Da, exp);
    endtask

    initial begin
        // ---------------- reset ----------------
        rst_n = 1'b0;
        ctl(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, itype(5'd1, 5'd0, 16'd0));
        #2;
        chk("rst_reg_da", bus.reg_Da, 32'd0);
        chk("rst_zero", {31'd0, bus.Zero}, 32'd1);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // ---------------- addi $1,$0,2015 / addi $2,$0,404 ----------------
        ctl(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, itype(5'd0, 5'd1, 16'd2015));
        #1;
        chk("addi1_seout", bus.seOut, 32'd2015);
        chk("addi1_zero", {31'd0, bus.Zero}, 32'd0);
        tick();
        ctl(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, itype(5'd0, 5'd2, 16'd404));
        tick();
        rdreg(5'd1, 32'd2015, "r1_2015");
        rdreg(5'd2, 32'd404, "r2_404");

        // ---------------- add $1,$1,$2 ----------------
        ctl(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, rtype(5'd1, 5'd2, 5'd1));
        #1;
        chk("add_old_da", bus.reg_Da, 32'd2015);
        chk("add_zero", {31'd0, bus.Zero}, 32'd0);
        tick();
        rdreg(5'd1, 32'd2419, "r1_2419");

        // ---------------- sw $2,0($0) then lw $3,0($0) ----------------
        ctl(1'bx, 1'b0, 1'b1, 2'b00, 1'b1, 1'bx, itype(5'd0, 5'd2, 16'd0));
        tick();
        rdreg(5'd2, 32'd404, "sw_r2_kept");
        rdreg(5'd1, 32'd2419, "sw_r1_kept");
        ctl(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, itype(5'd0, 5'd3, 16'd0));
        tick();
        rdreg(5'd3, 32'd404, "lw_r3");
        // byte address 256 -> word 64 -> aliases word 0
        ctl(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, itype(5'd0, 5'd6, 16'd256));
        tick();
        rdreg(5'd6, 32'd404, "lw_alias_r6");

        // ---------------- sub $4,$2,$2 ----------------
        ctl(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, itype(5'd0, 5'd4, 16'd77));
        tick();
        rdreg(5'd4, 32'd77, "r4_pre");
        ctl(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, rtype(5'd2, 5'd2, 5'd4));
        #1;
        chk("sub_zero", {31'd0, bus.Zero}, 32'd1);
        tick();
        rdreg(5'd4, 32'd0, "sub_r4");

        // ---------------- addi $5,$0,-4 ----------------
        ctl(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, itype(5'd0, 5'd5, 16'hFFFC));
        #1;
        chk("neg_seout", bus.seOut, 32'hFFFF_FFFC);
        tick();
        rdreg(5'd5, 32'hFFFF_FFFC, "r5_neg4");

        // ---------------- addi $0,$0,7 ----------------
        ctl(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, itype(5'd0, 5'd0, 16'd7));
        tick();
        rdreg(5'd0, 32'd0, "r0_zero");

        // ---------------- and / or ----------------
        // $6 = 0x0FF0; $9 = 0x7878 + 0x7878 = 0xF0F0
        ctl(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, itype(5'd0, 5'd6, 16'h0FF0));
        tick();
        ctl(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, itype(5'd0, 5'd9, 16'h7878));
        tick();
        ctl(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, rtype(5'd9, 5'd9, 5'd9));
        tick();
        rdreg(5'd9, 32'h0000_F0F0, "r9_f0f0");
        ctl(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, rtype(5'd9, 5'd6, 5'd7));
        tick();
        rdreg(5'd7, 32'h0000_00F0, "and_r7");
        ctl(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, rtype(5'd9, 5'd6, 5'd10));
        tick();
        rdreg(5'd10, 32'h0000_FFF0, "or_r10");

        // ---------------- RegWr and MemWr on the same edge ----------------
        // Imm 0x6808 carries Rd=13; byte address 0x6808 -> word 2 (aliased)
        ctl(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, itype(5'd0, 5'd2, 16'h6808));
        tick();
        rdreg(5'd13, 32'h0000_6808, "both_r13");
        ctl(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, itype(5'd0, 5'd14, 16'd8));
        tick();
        rdreg(5'd14, 32'd404, "both_mem_r14");

        // ---------------- mid-cycle reset ----------------
        // pending reg write to $11 and memory write, both must be lost
        ctl(1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, itype(5'd1, 5'd11, 16'd5));
        #2;
        chk("pre_rst_da", bus.reg_Da, 32'd2419);
        rst_n = 1'b0;
        #1;
        chk("rst_async_da", bus.reg_Da, 32'd0);
        tick();
        chk("rst_hold_da", bus.reg_Da, 32'd0);
        ctl(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, itype(5'd0, 5'd0, 16'd0));
        #2 rst_n = 1'b1;
        rdreg(5'd11, 32'd0, "rst_no_write_r11");
        rdreg(5'd2, 32'd0, "rst_r2");
        ctl(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, itype(5'd0, 5'd3, 16'd0));
        tick();
        rdreg(5'd3, 32'd0, "rst_dmem0");
        ctl(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, itype(5'd0, 5'd3, 16'd20));
        tick();
        rdreg(5'd3, 32'd0, "rst_dmem5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
